hist_capture_buf: RTL and testbench
===================================

Name: hist_capture_buf

Overview:
- Parametrised sample-history buffer: keeps the last DEPTH accepted samples of DATA_W bits in a circular store.
- Random read-back by age: rd_sel=0 is the newest sample.
- Trigger/post-trigger state machine freezes the history a programmable number of samples after an event (logic-analyser style).
- Sits between the dedicated-input pins and the output mux of a TT tile; it is the generalised successor of the fixed 7x8 shift history.

Parameters:
- DATA_W, 8, sample width in bits (>=1).
- DEPTH, 7, number of stored samples (>=2).
- SEL_W, $clog2(DEPTH+1), width of rd_sel and fill_count.
- POST_TRIG, 2, samples accepted after the trigger before freezing (0..DEPTH-1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- din_valid  in  1  accept din this cycle.
- din  in  DATA_W  sample data.
- trig  in  1  trigger event, level-sampled each cycle.
- clear  in  1  synchronous restart: empty buffer, return to RUN.
- rd_sel  in  SEL_W  sample age to read (0 = newest).
- rd_data  out  DATA_W  selected sample.
- rd_valid  out  1  rd_data holds a stored sample.
- fill_count  out  SEL_W  number of valid samples, 0..DEPTH.
- state  out  2  current state: 00 RUN, 01 POST, 10 FROZEN.

Behaviour:
- Reset and interface:
  - Reset rst_n, synchronous, active-low; clock clk.
  - Reset: storage=0, wr_ptr=0, fill_count=0, post_cnt=0, state=RUN, rd_data=0, rd_valid=0.
- Priority: reset > clear > trig > din_valid.
- Write:
  - In RUN or POST, din_valid=1 writes din at wr_ptr.
  - wr_ptr advances and wraps from DEPTH-1 to 0.
  - fill_count increments and saturates at DEPTH; when full, the oldest sample is overwritten.
  - In FROZEN, din_valid is ignored and nothing changes.
- Read (combinational by default):
  - Address = (wr_ptr-1-rd_sel) mod DEPTH.
  - If rd_sel >= fill_count: rd_data=0, rd_valid=0. This covers rd_sel >= DEPTH.
  - A write in cycle N is readable at rd_sel=0 from cycle N+1.
- State machine:
  - RUN, trig=1:
    - A din_valid sample in the same cycle is written and counts as the trigger sample.
    - If POST_TRIG=0, go to FROZEN; otherwise go to POST with post_cnt=POST_TRIG.
  - POST:
    - Each accepted sample decrements post_cnt.
    - The sample that takes post_cnt from 1 to 0 is written, and state becomes FROZEN next cycle.
    - trig is ignored in POST.
  - FROZEN: holds indefinitely. trig and din_valid are ignored. Reads stay live.
  - clear from any state: wr_ptr=0, fill_count=0, post_cnt=0, state=RUN.
    - Storage is not zeroed; it is hidden by fill_count.
    - A simultaneous din_valid sample is dropped.
    - A simultaneous trig is ignored.
- Reset mid-POST: returns to RUN with an empty buffer. No partial freeze is retained.
- All outputs are held stable when inputs are unchanged. No combinational path from din to rd_data.

Optional Feature:
- HIST_RD_REG_EN defined: rd_data and rd_valid are registered. Read latency is 1 cycle from rd_sel, and both outputs reset to 0.
- A write in cycle N is visible at rd_sel=0 from cycle N+2.
- HIST_RD_REG_EN undefined: combinational read as above, 0-cycle latency from rd_sel.

Decomposition:
- Package hist_capture_pkg holds:
  - state encoding typedef (RUN=2'b00, POST=2'b01, FROZEN=2'b10).
  - default DATA_W/DEPTH constants.
  - age-to-index helper function.
- One sub-module, hist_trig_fsm: owns state and post_cnt. It takes trig/clear/accept and outputs state plus write_allow.
- Storage, pointer and read mux stay in the top module.

Test Plan (DEPTH=7, DATA_W=8, POST_TRIG=2, combinational read):
- Reset, then write 0x11..0x19 (9 samples) -> fill_count=7; rd_sel=0 gives 0x19, rd_sel=6 gives 0x13; rd_sel=7 gives 0x00 with rd_valid=0.
- After reset, write 0xA0,0xA1 -> fill_count=2; rd_sel=1 gives 0xA0, valid; rd_sel=2 gives 0x00, invalid.
- Write 0x01..0x05; trig with 0x06; write 0x07,0x08,0x09 -> state=POST after trig, FROZEN after 0x08; rd_sel=0 gives 0x08; 0x09 not stored; fill_count=7.
- In FROZEN assert trig and din_valid for 5 cycles -> no change. Then clear with din_valid=1, din=0x55 -> state=RUN, fill_count=0, 0x55 dropped; next write 0x66 is readable at rd_sel=0.
- rst_n low for 1 cycle during POST (post_cnt=1) -> state=RUN, fill_count=0, rd_valid=0.
- With HIST_RD_REG_EN: write 0x3C in cycle N, rd_sel=0 -> rd_data=0x3C first seen at cycle N+2.

Source files
------------

// File: rtl/hist_capture_pkg.sv
// Shared types and helpers for the sample-history capture buffer.
// State encoding, default geometry and age-to-index mapping.
package hist_capture_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_POST   = 2'b01,
    ST_FROZEN = 2'b10
  } hist_state_e;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 7;

  // Physical slot of the sample that is `age` writes old.
  // Valid for age < depth; one wrap-add covers the range.
  function automatic int age_to_idx(
    input int ptr,
    input int age,
    input int depth
  );
    int t;
    t = ptr - 1 - age;
    if (t < 0) t = t + depth;
    return t;
  endfunction

endpackage

// File: rtl/hist_trig_fsm.sv
// Trigger / post-trigger controller for the history buffer.
// In: clk, rst_n, trig, clear, accept. Out: state, write_allow.
module hist_trig_fsm
  import hist_capture_pkg::*;
#(
  parameter int POST_TRIG = 2,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  input  logic        clear,
  input  logic        accept,
  output hist_state_e state,
  output logic        write_allow
);

  hist_state_e      st, st_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= ST_RUN;
      cnt <= '0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
    end
  end

  always_comb begin
    st_nx       = st;
    cnt_nx      = cnt;
    write_allow = 1'b0;
    if (clear) begin
      st_nx  = ST_RUN;
      cnt_nx = '0;
    end else begin
      unique case (st)
        ST_RUN: begin
          // the trigger-cycle sample is stored, not counted
          write_allow = accept;
          if (trig) begin
            if (POST_TRIG == 0) begin
              st_nx = ST_FROZEN;
            end else begin
              st_nx  = ST_POST;
              cnt_nx = CNT_W'(POST_TRIG);
            end
          end
        end
        ST_POST: begin
          write_allow = accept;
          if (accept) begin
            if (cnt == CNT_W'(1)) begin
              st_nx  = ST_FROZEN;
              cnt_nx = '0;
            end else begin
              cnt_nx = cnt - CNT_W'(1);
            end
          end
        end
        ST_FROZEN: begin
          write_allow = 1'b0;
        end
        default: begin
          st_nx  = ST_RUN;
          cnt_nx = '0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: rtl/hist_capture_buf.sv
// Circular sample history with trigger freeze and read-by-age.
// Ports: din_valid/din/trig/clear in; rd_sel -> rd_data/rd_valid;
// fill_count, state out. HIST_RD_REG_EN registers the read port.
module hist_capture_buf
  import hist_capture_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int SEL_W     = $clog2(DEPTH + 1),
  parameter int POST_TRIG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              trig,
  input  logic              clear,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [SEL_W-1:0]  fill_count,
  output logic [1:0]        state
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic              write_allow;
  hist_state_e       fsm_state;

  hist_trig_fsm #(
    .POST_TRIG (POST_TRIG),
    .CNT_W     (SEL_W)
  ) u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig        (trig),
    .clear       (clear),
    .accept      (din_valid),
    .state       (fsm_state),
    .write_allow (write_allow)
  );

  assign state = fsm_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      fill_count <= '0;
    end else if (clear) begin
      // storage left as-is; fill_count hides it
      wr_ptr     <= '0;
      fill_count <= '0;
    end else if (write_allow) begin
      mem[wr_ptr] <= din;
      if (wr_ptr == PTR_W'(DEPTH - 1)) wr_ptr <= '0;
      else wr_ptr <= wr_ptr + PTR_W'(1);
      if (fill_count != SEL_W'(DEPTH))
        fill_count <= fill_count + SEL_W'(1);
    end
  end

  logic              hit;
  int                idx;
  logic [DATA_W-1:0] rd_data_c;

  assign hit = rd_sel < fill_count;

  // age forced to 0 on a miss keeps idx in range
  always_comb begin
    idx       = age_to_idx(int'(wr_ptr),
                           hit ? int'(rd_sel) : 0, DEPTH);
    rd_data_c = hit ? mem[idx[PTR_W-1:0]] : '0;
  end

`ifdef HIST_RD_REG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= rd_data_c;
      rd_valid <= hit;
    end
  end
`else
  assign rd_data  = rd_data_c;
  assign rd_valid = hit;
`endif

endmodule

// File: tb/tb_hist_capture_buf.sv
// Directed self-checking bench for hist_capture_buf.
// DEPTH=7, DATA_W=8, POST_TRIG=2; adapts to HIST_RD_REG_EN.
module tb_hist_capture_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_valid;
  logic [7:0] din;
  logic       trig;
  logic       clear;
  logic [2:0] rd_sel;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fill_count;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hist_capture_buf #(
    .DATA_W    (8),
    .DEPTH     (7),
    .POST_TRIG (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .trig       (trig),
    .clear      (clear),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fill_count (fill_count),
    .state      (state)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    din_valid = 1'b0;
    trig      = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    din_valid = 1'b1;
    din       = d;
    step();
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // inputs must be idle; registered read needs one extra edge
  task automatic rd_chk(input string tag, input logic [2:0] sel,
                        input logic [7:0] ed, input logic ev);
    rd_sel = sel;
`ifdef HIST_RD_REG_EN
    step();
`else
    #1;
`endif
    chk({tag, "_data"}, rd_data, ed);
    chk({tag, "_valid"}, rd_valid, ev);
  endtask

  initial begin
    rst_n  = 1'b0;
    din    = '0;
    rd_sel = '0;
    idle();
    step();
    step();
    chk("rst_state", state, 2'b00);
    chk("rst_fill", fill_count, 3'd0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rd_valid", rd_valid, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) wr(8'h11 + 8'(i));
    chk("wrap_fill", fill_count, 3'd7);
    chk("wrap_state", state, 2'b00);
    rd_chk("wrap_sel0", 3'd0, 8'h19, 1'b1);
    rd_chk("wrap_sel6", 3'd6, 8'h13, 1'b1);
    rd_chk("wrap_sel7", 3'd7, 8'h00, 1'b0);

    do_reset();
    wr(8'hA0);
    wr(8'hA1);
    chk("part_fill", fill_count, 3'd2);
    rd_chk("part_sel1", 3'd1, 8'hA0, 1'b1);
    rd_chk("part_sel2", 3'd2, 8'h00, 1'b0);

    do_reset();
    for (int i = 1; i <= 5; i++) wr(8'(i));
    trig = 1'b1;
    wr(8'h06);
    trig = 1'b0;
    chk("trig_post", state, 2'b01);
    wr(8'h07);
    chk("post_1", state, 2'b01);
    wr(8'h08);
    chk("post_frozen", state, 2'b10);
    wr(8'h09);
    chk("frz_fill", fill_count, 3'd7);
    rd_chk("frz_sel0", 3'd0, 8'h08, 1'b1);
    rd_chk("frz_sel6", 3'd6, 8'h02, 1'b1);

    trig      = 1'b1;
    din_valid = 1'b1;
    din       = 8'hEE;
    for (int i = 0; i < 5; i++) step();
    idle();
    chk("hold_state", state, 2'b10);
    chk("hold_fill", fill_count, 3'd7);
    rd_chk("hold_sel0", 3'd0, 8'h08, 1'b1);

    clear     = 1'b1;
    trig      = 1'b1;
    din_valid = 1'b1;
    din       = 8'h55;
    step();
    idle();
    chk("clr_state", state, 2'b00);
    chk("clr_fill", fill_count, 3'd0);
    rd_chk("clr_sel0", 3'd0, 8'h00, 1'b0);
    wr(8'h66);
    chk("clr_wr_fill", fill_count, 3'd1);
    rd_chk("clr_wr_sel0", 3'd0, 8'h66, 1'b1);

    do_reset();
    wr(8'h01);
    trig = 1'b1;
    wr(8'h02);
    trig = 1'b0;
    wr(8'h03);
    chk("mid_post", state, 2'b01);
    rd_sel = 3'd0;
    do_reset();
    chk("mid_rst_state", state, 2'b00);
    chk("mid_rst_fill", fill_count, 3'd0);
    chk("mid_rst_valid", rd_valid, 1'b0);
    wr(8'h04);
    wr(8'h05);
    wr(8'h06);
    chk("mid_no_freeze", state, 2'b00);
    chk("mid_fill3", fill_count, 3'd3);

    do_reset();
    wr(8'h10);
    rd_sel = 3'd0;
    step();
    wr(8'h3C);
`ifdef HIST_RD_REG_EN
    chk("lat_n1", rd_data, 8'h10);
    step();
    chk("lat_n2", rd_data, 8'h3C);
`else
    chk("lat_n1", rd_data, 8'h3C);
    step();
    chk("lat_n2", rd_data, 8'h3C);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
